// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM-style pipeline stages.
//   exe_mem_ctrl_t : WB/MEM control bits carried from EXE to MEM.
//   exe_mem_beat_t : one EXE->MEM beat at the default widths (32-bit data, 4-bit dest).
//   STATE_*        : encoding of the skid-buffer FSM; also the occupancy value.
package arm_pipe_pkg;

    localparam int unsigned EXE_MEM_DATA_W = 32;
    localparam int unsigned EXE_MEM_DEST_W = 4;

    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
    } exe_mem_ctrl_t;

    // Control sits in the MSBs so generic code can clear it by slicing.
    typedef struct packed {
        exe_mem_ctrl_t               ctrl;
        logic [EXE_MEM_DATA_W-1:0]   alu_result;
        logic [EXE_MEM_DATA_W-1:0]   st_val;
        logic [EXE_MEM_DEST_W-1:0]   dest;
    } exe_mem_beat_t;

    localparam logic [1:0] STATE_EMPTY = 2'd0;
    localparam logic [1:0] STATE_ONE   = 2'd1;
    localparam logic [1:0] STATE_TWO   = 2'd2;

    typedef enum logic [1:0] {
        StEmpty = STATE_EMPTY,
        StOne   = STATE_ONE,
        StTwo   = STATE_TWO
    } pipe_state_e;

endpackage

// File: rtl/pipe_beat_reg.sv
// One pipeline slot: a beat register with a valid bit.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : invalidate the slot and zero its control bits (wins over load)
//   load     : capture d and mark the slot valid
//   d / q    : beat in / beat out (control field in the MSBs)
//   valid    : slot holds a live beat
// Payload bits are kept on clr; only control is zeroed, so an invalid slot
// never carries an asserted enable.
module pipe_beat_reg
    import arm_pipe_pkg::*;
#(
    parameter type beat_t = exe_mem_beat_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  load,
    input  beat_t d,
    output beat_t q,
    output logic  valid
);

    localparam int unsigned BeatW = $bits(beat_t);
    localparam int unsigned CtrlW = $bits(exe_mem_ctrl_t);

    logic [BeatW-1:0] beat_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else if (clr) begin
            beat_q[BeatW-1 -: CtrlW] <= '0;
            valid_q                  <= 1'b0;
        end else if (load) begin
            beat_q  <= d;
            valid_q <= 1'b1;
        end
    end

    assign q     = beat_t'(beat_q);
    assign valid = valid_q;

endmodule

// File: rtl/exe_mem_pipe_stage.sv
// EXE->MEM pipeline stage with valid/ready handshake, synchronous flush and
// occupancy report.
// Build option: define EXE_MEM_SKID_EN for a 2-entry skid buffer with a
// registered in_ready; otherwise a single register with combinational in_ready.
// Ports:
//   clk, rst (async, active-low), flush (sync, drops everything incl. this cycle's accept)
//   in_valid/in_ready + in_* payload   : from EXE
//   out_valid/out_ready + out_* payload: to MEM, held while out_valid & !out_ready
//   occupancy                          : beats held (0..2)
module exe_mem_pipe_stage
    import arm_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic              in_mem_w_en,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_st_val,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_st_val,
    output logic [DEST_W-1:0] out_dest,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        exe_mem_ctrl_t     ctrl;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] st_val;
        logic [DEST_W-1:0] dest;
    } beat_t;

    beat_t in_beat;
    beat_t main_d;
    beat_t main_q;
    logic  main_load;
    logic  main_clr;
    logic  main_valid;
    logic  accept;
    logic  pop;

    always_comb begin
        in_beat.ctrl.wb_en    = in_wb_en;
        in_beat.ctrl.mem_r_en = in_mem_r_en;
        in_beat.ctrl.mem_w_en = in_mem_w_en;
        in_beat.alu_result    = in_alu_result;
        in_beat.st_val        = in_st_val;
        in_beat.dest          = in_dest;
    end

    assign accept = in_valid & in_ready;
    assign pop    = main_valid & out_ready;

    pipe_beat_reg #(
        .beat_t (beat_t)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .clr   (main_clr),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q),
        .valid (main_valid)
    );

`ifdef EXE_MEM_SKID_EN

    beat_t       skid_q;
    logic        skid_load;
    logic        skid_clr;
    logic        skid_valid;
    pipe_state_e state_q;
    pipe_state_e state_d;
    logic        in_ready_q;

    pipe_beat_reg #(
        .beat_t (beat_t)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr   (skid_clr),
        .load  (skid_load),
        .d     (in_beat),
        .q     (skid_q),
        .valid (skid_valid)
    );

    // Refill main from skid whenever skid holds the older beat.
    assign main_d = skid_valid ? skid_q : in_beat;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            state_d  = StEmpty;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = StOne;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = StTwo;
                    end else if (pop) begin
                        main_clr = 1'b1;
                        state_d  = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                        state_d   = StOne;
                    end
                end
                default: begin
                    state_d  = StEmpty;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    // in_ready is registered from the next state so it never depends on out_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StTwo);
        end
    end

    assign in_ready  = in_ready_q;
    assign occupancy = state_q;

`else

    assign in_ready  = ~main_valid | out_ready;
    assign main_d    = in_beat;
    assign main_load = accept;
    assign main_clr  = flush | (pop & ~accept);
    assign occupancy = {1'b0, main_valid};

`endif

    assign out_valid      = main_valid;
    assign out_wb_en      = main_q.ctrl.wb_en;
    assign out_mem_r_en   = main_q.ctrl.mem_r_en;
    assign out_mem_w_en   = main_q.ctrl.mem_w_en;
    assign out_alu_result = main_q.alu_result;
    assign out_st_val     = main_q.st_val;
    assign out_dest       = main_q.dest;

endmodule

// File: tb/tb_exe_mem_pipe_stage.sv
// Self-checking bench for exe_mem_pipe_stage. A queue models the stage
// contents; each cycle the DUT outputs are compared against the queue head,
// its size and the expected in_ready. Directed sections pin the model with
// literal values. Build with or without EXE_MEM_SKID_EN.
module tb_exe_mem_pipe_stage;

    localparam int DW = 32;
    localparam int RW = 4;
`ifdef EXE_MEM_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef logic [3+2*DW+RW-1:0] beat_v;  // {wb, mem_r, mem_w, alu, st, dest}

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_wb_en;
    logic          in_mem_r_en;
    logic          in_mem_w_en;
    logic [DW-1:0] in_alu_result;
    logic [DW-1:0] in_st_val;
    logic [RW-1:0] in_dest;
    logic          out_valid;
    logic          out_ready;
    logic          out_wb_en;
    logic          out_mem_r_en;
    logic          out_mem_w_en;
    logic [DW-1:0] out_alu_result;
    logic [DW-1:0] out_st_val;
    logic [RW-1:0] out_dest;
    logic [1:0]    occupancy;

    beat_v model_q[$];
    int    n_checks;
    int    n_pass;

    exe_mem_pipe_stage #(
        .DATA_W (DW),
        .DEST_W (RW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_wb_en       (in_wb_en),
        .in_mem_r_en    (in_mem_r_en),
        .in_mem_w_en    (in_mem_w_en),
        .in_alu_result  (in_alu_result),
        .in_st_val      (in_st_val),
        .in_dest        (in_dest),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_wb_en      (out_wb_en),
        .out_mem_r_en   (out_mem_r_en),
        .out_mem_w_en   (out_mem_w_en),
        .out_alu_result (out_alu_result),
        .out_st_val     (out_st_val),
        .out_dest       (out_dest),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic beat_v dut_beat();
        return {out_wb_en, out_mem_r_en, out_mem_w_en, out_alu_result, out_st_val, out_dest};
    endfunction

    function automatic beat_v mk(input logic [31:0] alu, input logic [2:0] c);
        return {c, alu, alu ^ 32'hA5A5_0000, alu[3:0]};
    endfunction

    function automatic beat_v rand_beat();
        return {3'($urandom), 32'($urandom), 32'($urandom), 4'($urandom)};
    endfunction

    task automatic drive(input bit iv, input beat_v b, input bit ordy, input bit fl);
        in_valid = iv;
        {in_wb_en, in_mem_r_en, in_mem_w_en, in_alu_result, in_st_val, in_dest} = b;
        out_ready = ordy;
        flush = fl;
    endtask

    function automatic bit model_ready();
        if (CAP == 2) return model_q.size() < 2;
        return (model_q.size() == 0) || out_ready;
    endfunction

    task automatic model_check();
        chk("occupancy", 128'(occupancy), 128'(model_q.size()));
        chk("out_valid", 128'(out_valid), 128'(model_q.size() != 0));
        chk("in_ready", 128'(in_ready), 128'(model_ready()));
        if (model_q.size() != 0) chk("out_beat", 128'(dut_beat()), 128'(model_q[0]));
        else chk("idle_ctrl", 128'({out_wb_en, out_mem_r_en, out_mem_w_en}), 128'(0));
    endtask

    task automatic model_update();
        bit acc;
        bit pp;
        acc = in_valid && model_ready();
        pp  = (model_q.size() != 0) && out_ready;
        if (flush) begin
            model_q.delete();
        end else begin
            if (pp) void'(model_q.pop_front());
            if (acc) model_q.push_back({in_wb_en, in_mem_r_en, in_mem_w_en,
                                        in_alu_result, in_st_val, in_dest});
        end
    endtask

    // One cycle: drive at negedge, compare, advance model, land at posedge+1.
    task automatic step(input bit iv, input beat_v b, input bit ordy, input bit fl);
        @(negedge clk);
        drive(iv, b, ordy, fl);
        #1;
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_outputs", 128'(dut_beat()), 128'(0));
        @(negedge clk);
        rst = 1'b1;

        // Reset while full.
        step(1'b1, mk(32'h1, 3'b111), 1'b0, 1'b0);
        step(1'b1, mk(32'h2, 3'b111), 1'b0, 1'b0);
        chk("full_occupancy", 128'(occupancy), 128'(CAP));
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 128'(out_valid), 128'(0));
        chk("async_rst_occ", 128'(occupancy), 128'(0));
        model_q.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", 128'(in_ready), 128'(1));
        chk("post_rst_outputs", 128'(dut_beat()), 128'(0));

        // Streaming at full rate.
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, mk(32'(k), 3'b100), 1'b1, 1'b0);
            chk("stream_valid", 128'(out_valid), 128'(1));
            chk("stream_alu", 128'(out_alu_result), 128'(k));
            chk("stream_ready", 128'(in_ready), 128'(1));
        end
        step(1'b0, '0, 1'b1, 1'b0);

`ifdef EXE_MEM_SKID_EN
        // Back-pressure fills the skid; in_valid is ignored while full.
        step(1'b1, mk(32'h10, 3'b010), 1'b0, 1'b0);
        step(1'b1, mk(32'h20, 3'b001), 1'b0, 1'b0);
        chk("skid_occ2", 128'(occupancy), 128'(2));
        chk("skid_ready0", 128'(in_ready), 128'(0));
        chk("skid_hold_a", 128'(out_alu_result), 128'(32'h10));
        step(1'b1, mk(32'h99, 3'b111), 1'b1, 1'b0);
        chk("skid_then_b", 128'(out_alu_result), 128'(32'h20));
        chk("skid_occ1", 128'(occupancy), 128'(1));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("skid_drained", 128'(occupancy), 128'(0));
`else
        // Single register: in_ready follows out_ready combinationally.
        step(1'b1, mk(32'h10, 3'b010), 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, mk(32'h20, 3'b001), 1'b0, 1'b0);
        #1;
        chk("noskid_ready0", 128'(in_ready), 128'(0));
        chk("noskid_occ1", 128'(occupancy), 128'(1));
        out_ready = 1'b1;
        #1;
        chk("noskid_ready1", 128'(in_ready), 128'(1));
        model_check();
        model_update();
        @(posedge clk);
        #1;
        chk("noskid_b", 128'(out_alu_result), 128'(32'h20));
        step(1'b0, '0, 1'b1, 1'b0);
`endif

        // Flush while full, with a beat offered in the same cycle.
        for (int i = 0; i < CAP; i++) step(1'b1, mk(32'h11 + 32'(i), 3'b111), 1'b0, 1'b0);
        step(1'b1, mk(32'h30, 3'b111), 1'b1, 1'b1);
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_wb_en", 128'(out_wb_en), 128'(0));
        chk("flush_occ", 128'(occupancy), 128'(0));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("flush_no_c", 128'(out_valid), 128'(0));
        end

        // Random traffic against the model.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom % 4) != 0, rand_beat(), ($urandom % 3) != 0, ($urandom % 64) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
